alu_mdu: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit beside the single-cycle ALU in the CPU datapath.

---
 rtl/alu_mdu.sv | 194 +++++++++++++++++++
 tb/tb_alu_mdu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per clock into HI/LO.
// Optional MTHI/MTLO register writes are compiled in with `define MDU_MTHILO_EN.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_r_q, neg_r_d;
  logic               dz_pend_q, dz_pend_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
`ifdef MDU_MTHILO_EN
  logic               mt_done_q, mt_done_d;
`endif

  // Operand magnitudes and signs for the signed ops (op[0]==0)
  logic               sgn_op, sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  assign sgn_op = ~op[0];
  assign sa     = sgn_op & a[WIDTH-1];
  assign sb     = sgn_op & b[WIDTH-1];
  assign a_mag  = sa ? -a : a;
  assign b_mag  = sb ? -b : b;

  // Datapath step: multiplier lives in acc_lo and is shifted out LSB first
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ge;
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[WIDTH];

  // Sign correction applied while in FIX; shown on hi/lo during FIX and committed on exit
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;
  assign fix_hi   = dz_pend_q ? acc_lo_q : (is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH]);
  assign fix_lo   = dz_pend_q ? '1       : (is_div_q ? quo_fix : prod_fix[WIDTH-1:0]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_r_d   = neg_r_q;
    dz_pend_d = dz_pend_q;
    dz_d      = dz_q;
`ifdef MDU_MTHILO_EN
    mt_done_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (!op[2]) begin
            state_d   = S_RUN;
            dz_d      = 1'b0;
            is_div_d  = op[1];
            neg_d     = sa ^ sb;
            neg_r_d   = sa;
            dz_pend_d = op[1] && (b == '0);
            acc_hi_d  = '0;
            if (op[1]) begin
              // divide by zero keeps raw a for hi and skips iteration
              cnt_d    = (b == '0) ? CNT_W'(1) : CNT_W'(WIDTH);
              acc_lo_d = (b == '0) ? a : a_mag;
              opnd_d   = b_mag;
            end else begin
              cnt_d    = CNT_W'(WIDTH);
              acc_lo_d = b_mag;
              opnd_d   = a_mag;
            end
          end
`ifdef MDU_MTHILO_EN
          else if (op[2:1] == 2'b10) begin
            if (op[0]) lo_d = a;
            else       hi_d = a;
            mt_done_d = 1'b1;
            dz_d      = 1'b0;
          end
`endif
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!dz_pend_q) begin
            if (is_div_q) begin
              acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
            end else begin
              acc_hi_d = mul_sum[WIDTH:1];
              acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIX;
            dz_d    = dz_pend_q;
          end
        end
      end
      S_FIX: begin
        // commit point: flush is deliberately not looked at here
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_pend_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MDU_MTHILO_EN
      mt_done_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_r_q   <= neg_r_d;
      dz_pend_q <= dz_pend_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
`ifdef MDU_MTHILO_EN
      mt_done_q <= mt_done_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign div_by_zero = dz_q;
  assign hi          = (state_q == S_FIX) ? fix_hi : hi_q;
  assign lo          = (state_q == S_FIX) ? fix_lo : lo_q;
`ifdef MDU_MTHILO_EN
  assign done        = (state_q == S_FIX) | mt_done_q;
`else
  assign done        = (state_q == S_FIX);
`endif

endmodule

// File: tb/tb_alu_mdu.sv
// Directed table-driven bench for alu_mdu (WIDTH=32) plus hand sequences for flush/reset/MTLO.
module tb_alu_mdu;
  logic        clk, rstn, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  alu_mdu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          disturb;
    logic [31:0] hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Launch one op; returns cycles from start to done (start cycle = 0) and busy cycles seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit disturb, output int lat, output int bcnt);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (lat < 100) begin
      if (busy) bcnt++;
      if (done) break;
      if (disturb && lat == 5) begin
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bcnt, dseen;
    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3]  = '{3'b011, 32'd7,        32'd2,        1'b0, 32'h00000001, 32'h00000003, 1'b0, 33};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[5]  = '{3'b011, 32'h00001234, 32'd0,        1'b0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 2};
    vecs[6]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vecs[7]  = '{3'b000, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[8]  = '{3'b001, 32'h12345678, 32'h10,       1'b1, 32'h00000001, 32'h23456780, 1'b0, 33};
    vecs[9]  = '{3'b010, 32'd5,        32'd0,        1'b0, 32'h00000005, 32'hFFFFFFFF, 1'b1, 2};
    vecs[10] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[11] = '{3'b011, 32'hFFFFFFFF, 32'h10,       1'b0, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};

    rstn = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].disturb, lat, bcnt);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_dz", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dz});
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d_idle", i), {31'b0, busy}, 32'd0);
      chk($sformatf("v%0d_hi_hold", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo_hold", i), lo, vecs[i].lo);
    end

    // Flush at start+10 aborts; result of the last vector must survive
    @(negedge clk);
    op = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dseen = 0;
    repeat (9) begin
      @(posedge clk); #1;
      dseen += done;
    end
    chk("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", {31'b0, busy}, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      dseen += done;
    end
    chk("flush_no_done", 32'(dseen), 32'd0);
    chk("flush_hi", hi, 32'h0000000F);
    chk("flush_lo", lo, 32'h0FFFFFFF);

    // Flush and start together in IDLE: nothing launches
    @(negedge clk);
    op = 3'b011; a = 32'd9; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; dseen = 0;
    chk("fs_busy", {31'b0, busy}, 32'd0);
    repeat (5) begin
      @(posedge clk); #1;
      dseen += done;
    end
    chk("fs_no_done", 32'(dseen), 32'd0);
    chk("fs_lo", lo, 32'h0FFFFFFF);

    // Flush during FIX: commit still happens
    run_op(3'b000, 32'd6, 32'd7, 1'b0, lat, bcnt);
    chk("ffix_done", {31'b0, done}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("ffix_lo", lo, 32'd42);
    chk("ffix_hi", hi, 32'd0);
    chk("ffix_busy", {31'b0, busy}, 32'd0);

    // Reset mid-operation clears everything at once
    @(negedge clk);
    op = 3'b001; a = 32'hFFFFFFFF; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rmid_busy", {31'b0, busy}, 32'd0);
    chk("rmid_lo", lo, 32'd0);
    chk("rmid_hi", hi, 32'd0);
    chk("rmid_done", {31'b0, done}, 32'd0);
    @(negedge clk) rstn = 1'b1;

    run_op(3'b000, 32'd2, 32'd3, 1'b0, lat, bcnt);
    chk("post_rst_lat", 32'(lat), 32'd33);
    chk("post_rst_lo", lo, 32'd6);
    @(posedge clk); #1;

    // MTLO
    @(negedge clk);
    op = 3'b101; a = 32'hCAFEBABE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
`ifdef MDU_MTHILO_EN
    chk("mtlo_lo", lo, 32'hCAFEBABE);
    chk("mtlo_done", {31'b0, done}, 32'd1);
`else
    chk("mtlo_lo", lo, 32'd6);
    chk("mtlo_done", {31'b0, done}, 32'd0);
`endif
    @(posedge clk); #1;
    chk("mtlo_done_end", {31'b0, done}, 32'd0);
    chk("mtlo_hi", hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
